// File: rtl/vsa_pkg.sv
// Shared constants and types for the VSA 12-bit processor and its memory side.
package vsa_pkg;

    // Datapath geometry
    localparam int IW    = 12;            // instruction width
    localparam int DW    = 5;             // data word, PC and address width
    localparam int DEPTH = 2 ** DW;       // words per memory

    // Data address whose store ends the run
    localparam logic [DW-1:0] MAILBOX_ADDR_DEF = 5'd31;

    // Instruction fields: [11:9] opcode, [8:6] function, rest operands
    localparam int OPC_W = 3;
    localparam int FN_W  = 3;

    localparam logic [OPC_W-1:0] OP_LW  = 3'd0;   // all-zero word is LW R0, harmless
    localparam logic [OPC_W-1:0] OP_SW  = 3'd1;
    localparam logic [OPC_W-1:0] OP_ALU = 3'd2;
    localparam logic [OPC_W-1:0] OP_LI  = 3'd3;
    localparam logic [OPC_W-1:0] OP_BEQ = 3'd4;
    localparam logic [OPC_W-1:0] OP_JMP = 3'd5;

    localparam logic [FN_W-1:0] FN_ADD = 3'd0;
    localparam logic [FN_W-1:0] FN_SUB = 3'd1;
    localparam logic [FN_W-1:0] FN_AND = 3'd2;
    localparam logic [FN_W-1:0] FN_OR  = 3'd3;
    localparam logic [FN_W-1:0] FN_XOR = 3'd4;

    // Responder phases; the unused code 3 falls back to LOAD
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/vsa_ram.sv
// Width x depth register array: async clear, one sync write, one async read.
module vsa_ram #(
    parameter int W  = 8,
    parameter int D  = 32,
    parameter int AW = $clog2(D)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [D];

    // Storage: cleared by reset, one word written per enabled edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < D; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vsa_mem_responder.sv
// Memory-side responder: host preload, processor fetch/load/store, mailbox end.
module vsa_mem_responder
    import vsa_pkg::*;
#(
    parameter logic [DW-1:0] MAILBOX_ADDR = MAILBOX_ADDR_DEF,
    parameter int            CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    // host loader
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             ld_sel,
    input  logic [IW-1:0]    ld_data,
    input  logic             ld_last,
    // processor side
    output logic             cpu_run,
    input  logic [DW-1:0]    pc,
    output logic [IW-1:0]    instruction,
    input  logic [DW-1:0]    alu_addr,
    input  logic [DW-1:0]    dataout,
    input  logic             wr,
    output logic [DW-1:0]    datain,
    // status
    output logic             done,
    output logic [DW-1:0]    result,
    output logic [CNT_W-1:0] wr_count,
    output logic             ld_overflow
);

    // Pointers are one bit wider than an address so "full" is representable
    localparam logic [DW:0]      PTR_FULL = {1'b1, {DW{1'b0}}};
    localparam logic [DW:0]      PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    mem_state_t       state_q, state_d;
    logic [DW:0]      iptr_q, iptr_d;
    logic [DW:0]      dptr_q, dptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    res_q, res_d;
    logic             ovf_q, ovf_d;

    logic             ld_fire, st_fire;
    logic             imem_we, dmem_we;
    logic [DW-1:0]    dmem_waddr, dmem_wdata;
    logic [IW-1:0]    imem_rdata;
    logic [DW-1:0]    dmem_rdata;

    assign ld_fire = ld_valid && (state_q == LOAD);
    assign st_fire = wr && (state_q == RUN);

    // Loader and processor writes are exclusive by phase, so one port suffices
    assign imem_we    = ld_fire && !ld_sel && (iptr_q != PTR_FULL);
    assign dmem_we    = (ld_fire && ld_sel && (dptr_q != PTR_FULL)) || st_fire;
    assign dmem_waddr = (state_q == RUN) ? alu_addr : dptr_q[DW-1:0];
    assign dmem_wdata = (state_q == RUN) ? dataout  : ld_data[DW-1:0];

    vsa_ram #(.W(IW), .D(DEPTH), .AW(DW)) u_imem (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .we_i    (imem_we),
        .waddr_i (iptr_q[DW-1:0]),
        .wdata_i (ld_data),
        .raddr_i (pc),
        .rdata_o (imem_rdata)
    );

    vsa_ram #(.W(DW), .D(DEPTH), .AW(DW)) u_dmem (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .we_i    (dmem_we),
        .waddr_i (dmem_waddr),
        .wdata_i (dmem_wdata),
        .raddr_i (alu_addr),
        .rdata_o (dmem_rdata)
    );

    // Phase register plus loader pointers, store counter and mailbox capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
            iptr_q  <= '0;
            dptr_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iptr_q  <= iptr_d;
            dptr_q  <= dptr_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: loader handshakes in LOAD, stores and mailbox in RUN
    always_comb begin
        state_d = state_q;
        iptr_d  = iptr_q;
        dptr_d  = dptr_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            LOAD: begin
                if (ld_fire) begin
                    if (!ld_sel) begin
                        if (iptr_q == PTR_FULL) ovf_d  = 1'b1;
                        else                    iptr_d = iptr_q + PTR_ONE;
                    end else begin
                        if (dptr_q == PTR_FULL) ovf_d  = 1'b1;
                        else                    dptr_d = dptr_q + PTR_ONE;
                    end
                    // a dropped last word still ends the load
                    if (ld_last) state_d = RUN;
                end
            end
            RUN: begin
                if (st_fire) begin
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_ONE;
                    if (alu_addr == MAILBOX_ADDR) begin
                        res_d   = dataout;
                        state_d = DONE;
                    end
                end
            end
            DONE:    ;
            default: state_d = LOAD;
        endcase
    end

    // Outputs are pure decodes of the phase; fetch reads only while running
    assign ld_ready    = (state_q == LOAD);
    assign cpu_run     = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign instruction = (state_q == RUN) ? imem_rdata : '0;
    assign datain      = ((state_q == RUN) || (state_q == DONE)) ? dmem_rdata : '0;
    assign result      = res_q;
    assign wr_count    = cnt_q;
    assign ld_overflow = ovf_q;

endmodule

// File: tb/tb_vsa_mem_responder.sv
// Bench for vsa_mem_responder: directed loads/stores, behavioural model compare.
module tb_vsa_mem_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld_valid = 1'b0, ld_sel = 1'b0, ld_last = 1'b0;
    logic [11:0] ld_data = '0;
    logic        ld_ready, cpu_run, done, ld_overflow;
    logic [4:0]  pc = '0, alu_addr = '0, dataout = '0;
    logic        wr = 1'b0;
    logic [11:0] instruction;
    logic [4:0]  datain, result;
    logic [7:0]  wr_count;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    vsa_mem_responder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_sel      (ld_sel),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .cpu_run     (cpu_run),
        .pc          (pc),
        .instruction (instruction),
        .alu_addr    (alu_addr),
        .dataout     (dataout),
        .wr          (wr),
        .datain      (datain),
        .done        (done),
        .result      (result),
        .wr_count    (wr_count),
        .ld_overflow (ld_overflow)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // mode: 0 loading, 1 running, 2 finished
    int          m_mode = 0;
    logic [11:0] m_imem [32];
    logic [4:0]  m_dmem [32];
    int          m_iptr = 0, m_dptr = 0, m_cnt = 0;
    logic [4:0]  m_res = '0;
    bit          m_ovf = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= 0; m_iptr <= 0; m_dptr <= 0; m_cnt <= 0;
            m_res <= '0; m_ovf <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                m_imem[i] <= '0;
                m_dmem[i] <= '0;
            end
        end else if (m_mode == 0) begin
            if (ld_valid) begin
                if (!ld_sel) begin
                    if (m_iptr < 32) begin
                        m_imem[m_iptr] <= ld_data;
                        m_iptr <= m_iptr + 1;
                    end else m_ovf <= 1'b1;
                end else begin
                    if (m_dptr < 32) begin
                        m_dmem[m_dptr] <= ld_data[4:0];
                        m_dptr <= m_dptr + 1;
                    end else m_ovf <= 1'b1;
                end
                if (ld_last) m_mode <= 1;
            end
        end else if (m_mode == 1) begin
            if (wr) begin
                m_dmem[alu_addr] <= dataout;
                if (m_cnt < 255) m_cnt <= m_cnt + 1;
                if (alu_addr == 5'd31) begin
                    m_res  <= dataout;
                    m_mode <= 2;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle compare against the model, away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_ld_ready", 32'(ld_ready), 32'(m_mode == 0));
            chk("m_cpu_run",  32'(cpu_run),  32'(m_mode == 1));
            chk("m_done",     32'(done),     32'(m_mode == 2));
            chk("m_instr",    32'(instruction), (m_mode == 1) ? 32'(m_imem[pc]) : 32'd0);
            chk("m_datain",   32'(datain),   (m_mode != 0) ? 32'(m_dmem[alu_addr]) : 32'd0);
            chk("m_result",   32'(result),   32'(m_res));
            chk("m_wr_count", 32'(wr_count), 32'(m_cnt));
            chk("m_overflow", 32'(ld_overflow), 32'(m_ovf));
        end
    end

    // ---------------- stimulus helpers (start/end at posedge+1) ----------------
    task automatic ld_word(input logic sel, input logic [11:0] data, input logic last);
        ld_valid = 1'b1; ld_sel = sel; ld_data = data; ld_last = last;
        @(posedge clock); #1;
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic store(input logic [4:0] addr, input logic [4:0] data);
        alu_addr = addr; dataout = data; wr = 1'b1;
        @(posedge clock); #1;
        wr = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk_en = 1'b1;
        // reset state
        chk("rst_ld_ready", 32'(ld_ready), 1);
        chk("rst_cpu_run",  32'(cpu_run), 0);
        chk("rst_done",     32'(done), 0);
        chk("rst_result",   32'(result), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_overflow", 32'(ld_overflow), 0);

        // 1: load handshake
        ld_word(1'b0, 12'h3A5, 1'b0);
        ld_word(1'b0, 12'h001, 1'b0);
        chk("t1_run_early", 32'(cpu_run), 0);
        ld_word(1'b1, 12'hFE7, 1'b1);      // dmem takes low 5 bits = 7
        chk("t1_cpu_run", 32'(cpu_run), 1);
        chk("t1_ld_ready", 32'(ld_ready), 0);

        // 2: fetch and load in RUN
        pc = 5'd1; alu_addr = 5'd0; #1;
        chk("t2_instr1", 32'(instruction), 32'h001);
        chk("t2_datain0", 32'(datain), 32'd7);
        pc = 5'd0; #1;
        chk("t2_instr0", 32'(instruction), 32'h3A5);
        @(posedge clock); #1;

        // 3: stores
        store(5'd4, 5'd9);
        store(5'd4, 5'd3);
        alu_addr = 5'd4; #1;
        chk("t3_dmem4", 32'(datain), 32'd3);
        chk("t3_wr_count", 32'(wr_count), 32'd2);
        chk("t3_done", 32'(done), 0);

        // 4: mailbox
        pc = 5'd1;
        store(5'd31, 5'd21);
        chk("t4_result", 32'(result), 32'd21);
        chk("t4_done", 32'(done), 1);
        chk("t4_instr", 32'(instruction), 32'd0);
        chk("t4_cpu_run", 32'(cpu_run), 0);
        store(5'd4, 5'd1);
        alu_addr = 5'd4; #1;
        chk("t4_dmem4", 32'(datain), 32'd3);
        chk("t4_wr_count", 32'(wr_count), 32'd3);
        alu_addr = 5'd31; #1;
        chk("t4_dmem31", 32'(datain), 32'd21);
        @(posedge clock); #1;

        // 5: instruction memory overflow
        do_reset();
        for (int i = 0; i < 32; i++) ld_word(1'b0, 12'h100 + 12'(i), 1'b0);
        chk("t5_ovf_early", 32'(ld_overflow), 0);
        ld_word(1'b0, 12'hABC, 1'b1);
        chk("t5_overflow", 32'(ld_overflow), 1);
        chk("t5_cpu_run", 32'(cpu_run), 1);
        pc = 5'd31; alu_addr = 5'd0; #1;
        chk("t5_imem31", 32'(instruction), 32'h11F);
        chk("t5_dmem0_clr", 32'(datain), 0);
        pc = 5'd0; #1;
        chk("t5_imem0", 32'(instruction), 32'h100);

        // store counter saturation; the saturating store still writes
        for (int i = 0; i < 256; i++) store(5'd2, 5'(i));
        for (int i = 0; i < 3; i++) store(5'd2, 5'd17);
        alu_addr = 5'd2; #1;
        chk("sat_wr_count", 32'(wr_count), 32'd255);
        chk("sat_dmem2", 32'(datain), 32'd17);
        chk("sat_done", 32'(done), 0);
        @(posedge clock); #1;

        // 6: reset mid-run
        do_reset();
        ld_word(1'b0, 12'h055, 1'b1);
        store(5'd4, 5'd9);
        store(5'd5, 5'd2);
        chk("t6_pre_count", 32'(wr_count), 32'd2);
        #3;                                 // mid-cycle, away from any edge
        reset_n = 1'b0; #1;
        chk("t6_async_ready", 32'(ld_ready), 1);
        chk("t6_async_run", 32'(cpu_run), 0);
        chk("t6_async_count", 32'(wr_count), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        ld_word(1'b1, 12'h00C, 1'b1);
        alu_addr = 5'd4; pc = 5'd0; #1;
        chk("t6_dmem4", 32'(datain), 0);
        chk("t6_imem0", 32'(instruction), 0);
        alu_addr = 5'd0; #1;
        chk("t6_dmem0", 32'(datain), 32'd12);
        @(posedge clock); #1;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vsa_mem_responder.md
Name: vsa_mem_responder

Overview:
Memory-side responder for the VSA 12-bit processor. It holds the instruction memory (32x12) and the data memory (32x5). It answers the processor's instruction-fetch and data-load/store port, and it preloads both memories from a host through a valid/ready loader. A memory-mapped mailbox store ends the run and presents the result to the host.

Parameters:
IW, 12, instruction width
DW, 5, data word width (equal to the PC and address width)
DEPTH, 32, words per memory (2**DW)
MAILBOX_ADDR, 5'd31, data address whose store ends the run
CNT_W, 8, width of the store counter

Ports:
clock  input  1  master clock, rising edge
reset_n  input  1  asynchronous, active-low reset
ld_valid  input  1  host loader word valid
ld_ready  output  1  loader ready; high only in LOAD
ld_sel  input  1  target memory: 0 = instruction memory, 1 = data memory (data memory takes ld_data[4:0])
ld_data  input  IW  loader word
ld_last  input  1  final loader word
cpu_run  output  1  high in RUN; gates the processor clock enable externally
pc  input  DW  processor fetch address
instruction  output  IW  fetch data
alu_addr  input  DW  processor data address
dataout  input  DW  processor store data
wr  input  1  processor store strobe
datain  output  DW  load data
done  output  1  high in DONE
result  output  DW  value captured by the mailbox store
wr_count  output  CNT_W  stores committed in RUN, saturating
ld_overflow  output  1  sticky: a loader word was dropped because its target was full

Behaviour:
- Reset (asynchronous, active-low):
  - state = LOAD; both memories cleared to 0; both load pointers = 0.
  - Outputs after reset: result = 0, wr_count = 0, ld_overflow = 0, done = 0, cpu_run = 0, ld_ready = 1.
  - Asserting reset mid-run or mid-load aborts immediately. All contents are lost.
- States: LOAD (0), RUN (1), DONE (2). Encoding is 2 bits; code 3 is illegal and returns to LOAD.
- LOAD:
  - A handshake completes when ld_valid and ld_ready are both high at a clock edge.
  - Sel 0 writes imem[iptr] and increments iptr; sel 1 writes dmem[dptr] and increments dptr.
  - If the selected pointer already equals DEPTH, the word is dropped and ld_overflow sets. Pointers are DW+1 bits and do not wrap.
  - A handshake with ld_last high moves to RUN on the next cycle, even if that word was dropped.
- RUN:
  - instruction = imem[pc] and datain = dmem[alu_addr], both combinational (zero-latency read). The processor samples them on its own edges.
  - A store is wr high at a clock edge:
    - It writes dmem[alu_addr] <= dataout.
    - It increments wr_count, saturating at 2**CNT_W-1.
    - If alu_addr == MAILBOX_ADDR, it also captures result <= dataout and moves to DONE on the next cycle.
  - The mailbox store is written into dmem like any other store.
  - ld_valid is ignored (ld_ready = 0).
- DONE:
  - Memories are frozen; wr is ignored and wr_count is held.
  - instruction is forced to 0 (LW R0 — harmless); datain still reads dmem.
  - DONE is left only by reset.
- Simultaneous events:
  - In LOAD, wr is ignored and fetch outputs are 0.
  - A store and a counter saturation in the same cycle: the write still occurs.
  - Loader and processor never write in the same cycle, because the states are exclusive.
- Widths: all address arithmetic is DW bits. Loader data to dmem is truncated to ld_data[DW-1:0].

Decomposition:
- Shared package vsa_pkg holds:
  - IW, DW, and DEPTH;
  - the opcode and function constants;
  - a typedef enum logic [1:0] {LOAD, RUN, DONE} mem_state_t;
  - the MAILBOX_ADDR default.
- One natural sub-module: vsa_ram, a parameterized width x depth array with:
  - asynchronous clear;
  - one synchronous write port;
  - one asynchronous read port.
- vsa_mem_responder instantiates vsa_ram twice and holds the FSM, pointers and counters.

Test Plan:
1. Load, handshake: reset, then load imem words 12'h3A5, 12'h001 (sel 0) and dmem word 5'd7 (sel 1, ld_last) → imem[0] = 3A5, imem[1] = 001, dmem[0] = 7; cpu_run rises the cycle after the last handshake; ld_ready falls at the same time.
2. Fetch and load in RUN: pc = 1, alu_addr = 0 → instruction = 12'h001, datain = 5'd7 in the same cycle.
3. Stores: wr pulses at alu_addr 4 with dataout 9, then 4 with 3 → dmem[4] = 3, wr_count = 2, done stays 0.
4. Mailbox: wr at alu_addr 31 with dataout 5'd21 → result = 21, done = 1 next cycle, instruction = 0. A later wr at alu_addr 4 with dataout 1 leaves dmem[4] = 3 and wr_count = 3.
5. Overflow: 33 sel-0 words, the last with ld_last → ld_overflow = 1; imem[31] holds the 32nd word; the state goes to RUN.
6. Reset mid-run: reset_n low for one cycle during RUN after 2 stores → state LOAD, wr_count = 0, dmem[4] = 0, ld_ready = 1 asynchronously.
